// File: rtl/fifo_rdselector.sv
// ---------------------------------------------------------------------------
// fifo_rdselector
//
// CHANNELS_CNT independent circular-buffer FIFOs, each with its own write
// port, drained through one shared first-word-fall-through read port.
//
// Optional feature (compile-time macro FIFO_RDSELECTOR_RR_EN):
//   defined   - an internal round-robin pointer chooses the read channel and
//               i_channel_rd_select is ignored.
//   undefined - i_channel_rd_select chooses the read channel directly.
//
// Ports
//   clk                    single clock, rising edge
//   rst_all                synchronous active-high reset, all channels + arbiter
//   rst_channels[k]        synchronous active-high reset of channel k only
//   i_wr_valid_channels[k] write strobe of channel k
//   i_wr_data_channels[k]  write data of channel k
//   i_channel_rd_select    channel presented on the read port (non-RR build)
//   i_rd_en                pop the head of the presented channel
//   o_rd_valid             presented channel holds data, o_rd_data is valid
//   o_rd_data              head word of the presented channel
//   o_rd_channel           channel currently presented on the read port
//   o_ready_channels[k]    channel k not full
//   o_empty_channels[k]    channel k empty
//   o_full_channels[k]     channel k full
//   o_overflow_channels[k] sticky: a write to channel k was dropped
//   o_fill_count_channels  entries stored per channel (0..CHANNEL_DEPTH)
//
// Handshake: a word is transferred on a rising edge where o_rd_valid and
// i_rd_en are both high; i_rd_en with o_rd_valid low has no effect. A write
// to channel k is taken on an edge where i_wr_valid_channels[k] is high and
// the channel is not full or is popped in the same cycle; otherwise it is
// dropped and the overflow flag is set.
// ---------------------------------------------------------------------------
module fifo_rdselector #(
  parameter int CHANNEL_WIDTH = 32,
  parameter int CHANNEL_DEPTH = 128,
  parameter int CHANNELS_CNT  = 5
) (
  input  logic                                                 clk,
  input  logic                                                 rst_all,
  input  logic [CHANNELS_CNT-1:0]                              rst_channels,
  input  logic [CHANNELS_CNT-1:0]                              i_wr_valid_channels,
  input  logic [CHANNELS_CNT-1:0][CHANNEL_WIDTH-1:0]           i_wr_data_channels,
  input  logic [$clog2(CHANNELS_CNT)-1:0]                      i_channel_rd_select,
  input  logic                                                 i_rd_en,
  output logic                                                 o_rd_valid,
  output logic [CHANNEL_WIDTH-1:0]                             o_rd_data,
  output logic [$clog2(CHANNELS_CNT)-1:0]                      o_rd_channel,
  output logic [CHANNELS_CNT-1:0]                              o_ready_channels,
  output logic [CHANNELS_CNT-1:0]                              o_empty_channels,
  output logic [CHANNELS_CNT-1:0]                              o_full_channels,
  output logic [CHANNELS_CNT-1:0]                              o_overflow_channels,
  output logic [CHANNELS_CNT-1:0][$clog2(CHANNEL_DEPTH):0]     o_fill_count_channels
);

  localparam int SEL_W = $clog2(CHANNELS_CNT);
  localparam int PTR_W = $clog2(CHANNEL_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CHANNELS_CNT-1:0]                    full_q;
  logic [CHANNELS_CNT-1:0]                    empty_q;
  logic [CHANNELS_CNT-1:0]                    ovf_q;
  logic [CHANNELS_CNT-1:0]                    pop;
  logic [CHANNELS_CNT-1:0][CNT_W-1:0]         cnt_q;
  logic [CHANNELS_CNT-1:0][CHANNEL_WIDTH-1:0] head;

  logic [SEL_W-1:0]         sel;
  logic                     rd_valid;
  logic [CHANNEL_WIDTH-1:0] rd_data;

  // -------------------------------------------------------------------------
  // Read channel selection
  // -------------------------------------------------------------------------
`ifdef FIFO_RDSELECTOR_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_nxt;

  // Next non-empty channel strictly after rr_ptr, wrapping; the current
  // channel itself is tried last so a lone busy channel keeps being served.
  always_comb begin
    int   c;
    logic found;
    c      = 0;
    found  = 1'b0;
    rr_nxt = rr_ptr;
    for (int i = 1; i <= CHANNELS_CNT; i++) begin
      c = (int'(rr_ptr) + i) % CHANNELS_CNT;
      if (!found && !empty_q[c]) begin
        found  = 1'b1;
        rr_nxt = SEL_W'(c);
      end
    end
  end

  // Move on after every pop (one word per channel per turn) or when parked
  // on an empty channel; hold when nothing is pending anywhere.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      rr_ptr <= '0;
    end else if (|pop || !rd_valid) begin
      rr_ptr <= rr_nxt;
    end
  end

  assign sel = rr_ptr;
`else
  assign sel = i_channel_rd_select;
`endif

  // -------------------------------------------------------------------------
  // Read port mux; an out-of-range select matches no channel, so the port
  // shows not-valid and no pop is generated.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_valid = 1'b0;
    rd_data  = '0;
    pop      = '0;
    for (int k = 0; k < CHANNELS_CNT; k++) begin
      if (sel == SEL_W'(k)) begin
        rd_valid = ~empty_q[k];
        rd_data  = head[k];
      end
    end
    for (int k = 0; k < CHANNELS_CNT; k++) begin
      pop[k] = i_rd_en & rd_valid & (sel == SEL_W'(k));
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel circular buffers
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < CHANNELS_CNT; k++) begin : g_ch
    logic [CHANNEL_WIDTH-1:0] mem [CHANNEL_DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         cnt;
    logic                     full;
    logic                     empty;
    logic                     ovf;
    logic                     ch_rst;
    logic                     wr_acc;
    logic [CNT_W-1:0]         cnt_nxt;

    assign ch_rst  = rst_all | rst_channels[k];
    // A pop on a full channel frees the slot the same write lands in.
    assign wr_acc  = i_wr_valid_channels[k] & (~full | pop[k]);
    assign cnt_nxt = cnt + CNT_W'(wr_acc) - CNT_W'(pop[k]);
    assign head[k] = mem[rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
      if (wr_acc && !ch_rst) begin
        mem[wr_ptr] <= i_wr_data_channels[k];
      end
    end

    always_ff @(posedge clk) begin
      if (ch_rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        full   <= 1'b0;
        empty  <= 1'b1;
        ovf    <= 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop[k]) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (i_wr_valid_channels[k] && !wr_acc) begin
          ovf <= 1'b1;
        end
        cnt   <= cnt_nxt;
        full  <= (cnt_nxt == CNT_W'(CHANNEL_DEPTH));
        empty <= (cnt_nxt == '0);
      end
    end

    assign full_q[k]  = full;
    assign empty_q[k] = empty;
    assign ovf_q[k]   = ovf;
    assign cnt_q[k]   = cnt;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_rd_valid            = rd_valid;
  assign o_rd_data             = rd_data;
  assign o_rd_channel          = sel;
  assign o_ready_channels      = ~full_q;
  assign o_empty_channels      = empty_q;
  assign o_full_channels       = full_q;
  assign o_overflow_channels   = ovf_q;
  assign o_fill_count_channels = cnt_q;

endmodule
